// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data-memory controller: load/store width
// encodings, controller state type and the funct3 legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_t;

    // Unsigned widths exist only for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for
// stores, lane extraction plus sign/zero extension for loads, and the
// natural-alignment check for half and word accesses.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  rbyte_s;
    logic [15:0] rhalf_s;

    // Select the addressed byte/half of the read word and decode per width.
    always_comb begin
        rbyte_s   = rword[{addr_lo, 3'b000} +: 8];
        rhalf_s   = addr_lo[1] ? rword[31:16] : rword[15:0];
        byte_en   = 4'b0000;
        wdata_sh  = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
        misalign  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'h000000, rbyte_s}
                                      : {{24{rbyte_s[7]}}, rbyte_s};
                misalign  = 1'b0;
            end
            F3_H, F3_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'h0000, rhalf_s}
                                      : {{16{rhalf_s[15]}}, rhalf_s};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                byte_en   = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
                misalign  = (addr_lo != 2'b00);
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_sh  = 32'h0000_0000;
                rdata_ext = 32'h0000_0000;
                misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32 core: one outstanding request,
// valid/ready request side, single-cycle response strobe, byte-lane writes
// and a configurable delay between request accept and the memory access.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state_r;
    dmem_state_t state_s;

    logic [1:0]  cnt_r;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept_s;
    logic          access_s;
    logic          range_err_s;
    logic          err_s;
    logic [AW-1:0] word_idx_s;
    logic [3:0]    byte_en_s;
    logic [31:0]   wdata_sh_s;
    logic [31:0]   rdata_ext_s;
    logic          misalign_s;

    assign accept_s    = req_valid && (state_r == IDLE);
    assign access_s    = (state_r == ACCESS) && (cnt_r == 2'd0);
    assign word_idx_s  = addr_r[AW+1:2];
    // Compare the full word address so high address bits cannot alias.
    assign range_err_s = ({2'b00, addr_r[31:2]} >= 32'(DEPTH_WORDS));
    assign err_s       = f3_illegal(we_r, f3_r) || misalign_s || range_err_s;

    lsu_align u_align (
        .funct3    (f3_r),
        .addr_lo   (addr_r[1:0]),
        .wdata     (wdata_r),
        .rword     (mem[word_idx_s]),
        .byte_en   (byte_en_s),
        .wdata_sh  (wdata_sh_s),
        .rdata_ext (rdata_ext_s),
        .misalign  (misalign_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept -> count down latency -> one response cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 2'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Outputs decoded from registered state and registered response data.
    always_comb begin
        req_ready  = (state_r == IDLE);
        resp_valid = (state_r == RESP);
        resp_rdata = rdata_r;
        resp_err   = err_r;
    end

    // Capture the request, run the latency counter, latch the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 2'd0;
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r   <= 2'(READ_LATENCY - 1);
                we_r    <= req_we;
                f3_r    <= req_funct3;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end else if ((state_r == ACCESS) && (cnt_r != 2'd0)) begin
                cnt_r <= cnt_r - 2'd1;
            end
            // Response fields are non-zero only during the RESP cycle.
            if (access_s) begin
                err_r   <= err_s;
                rdata_r <= (err_s || we_r) ? 32'h0000_0000 : rdata_ext_s;
            end else begin
                err_r   <= 1'b0;
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    // Byte-lane store at the access edge; reset or any error blocks it.
    always_ff @(posedge clk) begin
        if (!rst && access_s && we_r && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem[word_idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised successor to the single-cycle word-only data memory: a data-memory controller for the RV32 core that supports RISC-V load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Uses byte-lane writes, alignment and range checking, and a configurable access latency.
- Exposes a valid/ready request and valid response handshake, so the core can move to a multi-cycle or pipelined datapath.
- Allows one outstanding request.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 4
READ_LATENCY, 1, access-delay cycles between request accept and memory access; legal range 1..4

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V load/store funct3 width encoding
req_addr  input  32  byte address
req_wdata  input  32  store data, taken from low bits (byte [7:0], half [15:0])
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset: rst is sampled on the posedge of clk; synchronous, active-high.
  - Outputs: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory array is not cleared.
- Accept rule: a request is accepted on an edge where req_valid && req_ready. All req_* fields are registered at that edge and later changes are ignored.
- FSM states:
  - IDLE: req_ready=1. On accept, load cnt=READ_LATENCY-1 and go to ACCESS.
  - ACCESS: req_ready=0. When cnt!=0, decrement. When cnt==0, perform the access at this edge and go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Timing: if a request is accepted at the end of cycle T:
  - ACCESS spans T+1..T+READ_LATENCY.
  - resp_valid=1 in T+READ_LATENCY+1.
  - req_ready returns to 1 in T+READ_LATENCY+2.
  - Back-to-back throughput is one request per READ_LATENCY+2 cycles.
- Responses: there is no response backpressure. resp_rdata and resp_err are valid only while resp_valid=1 and are driven to 0 otherwise.
- Addressing: word index = addr[$clog2(DEPTH_WORDS)+1:2]; lane = addr[1:0]; byte order is little-endian.
- Error conditions (any one sets resp_err):
  - funct3 in {011,110,111};
  - store with funct3 in {100,101};
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- On error: no memory write, resp_rdata=0, resp_err=1, same latency as a normal access.
- Loads: the word is read at the access edge.
  - 000: sign-extend byte at lane.
  - 100: zero-extend byte at lane.
  - 001: sign-extend half at lane (0 or 2).
  - 101: zero-extend half at lane (0 or 2).
  - 010: full word.
- Stores: byte enables are written at the access edge; unselected bytes are unchanged. resp_rdata=0, resp_err=0.
  - 000 (SB): 1 enable at lane.
  - 001 (SH): 2 enables at lanes 0-1 or 2-3.
  - 010 (SW): all 4 enables.
- Reset mid-operation: rst overrides everything. If rst=1 on the access edge, the write is suppressed and the in-flight request is dropped with no response.
- Read-after-write: a load accepted after a store's resp_valid sees the stored data.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_t.
- Sub-module lsu_align (combinational):
  - inputs: funct3, addr[1:0], wdata, rword;
  - outputs: byte_en[3:0], shifted wdata, extended rdata, misalign flag.
- dmem_ctrl holds the FSM, latency counter, request registers and memory array.

Test Plan:
- Reset and handshake: READ_LATENCY=1. Assert rst for 2 cycles, then SW addr=0x10 wdata=0xDEADBEEF accepted at T -> resp_valid only in T+2, resp_err=0, req_ready low T+1..T+2, high T+3.
- Load extensions: after the SW above:
  - LB 0x13 -> 0xFFFFFFDE;
  - LBU 0x13 -> 0x000000DE;
  - LH 0x12 -> 0xFFFFDEAD;
  - LHU 0x10 -> 0x0000BEEF;
  - LW 0x10 -> 0xDEADBEEF.
- Byte-lane store: SB addr=0x11 wdata=0x000000AA, then LW 0x10 -> 0xDEADAAEF.
- Errors:
  - LW 0x12 -> resp_err=1, rdata=0;
  - SH 0x11 -> resp_err=1, following LW 0x10 unchanged;
  - LW 4*DEPTH_WORDS -> resp_err=1;
  - funct3=011 -> resp_err=1.
- Latency sweep: READ_LATENCY=1..4. Held req_valid with 3 back-to-back loads -> accepts spaced exactly READ_LATENCY+2 cycles apart, one resp_valid per accept.
- Reset mid-operation: READ_LATENCY=3. SW 0x20 wdata=0x12345678 accepted, rst pulsed in the second ACCESS cycle -> no resp_valid, then LW 0x20 returns the pre-store value (0 after preloading 0).
